// File: rtl/vai_tx_audit_if.sv
// ---------------------------------------------------------------------------
// vai_tx_audit_if
//
// Purpose: Tx bundle carried between a sub-AFU and the Tx mux. Holds the c0
// read request channel, the c1 write request channel (with its cache-line
// data) and the c2 MMIO read response channel.
//
// Handshake: every channel is a valid-only qualifier. There is no ready or
// backpressure on this bundle; a producer asserts <ch>_valid for exactly the
// cycles that carry a request, and the consumer must accept it in that cycle.
// Almost-full throttling is done further upstream.
//
// Modports:
//   master : drives all fields (the audited output side of the auditor).
//   slave  : samples all fields (the sub-AFU-facing input side).
// ---------------------------------------------------------------------------
interface vai_tx_audit_if;
    // c0: read request
    logic         c0_valid;
    logic [41:0]  c0_address;
    logic [15:0]  c0_mdata;
    logic [3:0]   c0_req_type;
    logic [1:0]   c0_cl_len;

    // c1: write request
    logic         c1_valid;
    logic [41:0]  c1_address;
    logic [15:0]  c1_mdata;
    logic [3:0]   c1_req_type;
    logic [1:0]   c1_cl_len;
    logic [511:0] c1_data;

    // c2: MMIO read response
    logic         c2_mmio_rd_valid;
    logic [8:0]   c2_tid;
    logic [63:0]  c2_data;

    modport master (
        output c0_valid, c0_address, c0_mdata, c0_req_type, c0_cl_len,
        output c1_valid, c1_address, c1_mdata, c1_req_type, c1_cl_len, c1_data,
        output c2_mmio_rd_valid, c2_tid, c2_data
    );

    modport slave (
        input c0_valid, c0_address, c0_mdata, c0_req_type, c0_cl_len,
        input c1_valid, c1_address, c1_mdata, c1_req_type, c1_cl_len, c1_data,
        input c2_mmio_rd_valid, c2_tid, c2_data
    );
endinterface

// File: rtl/vai_tx_audit.sv
// ---------------------------------------------------------------------------
// vai_tx_audit
//
// Purpose: per-sub-AFU Tx auditor. Relocates c0/c1 request addresses by the
// sub-AFU's programmed offset (modulo 2^42), tags mdata[15:16-VMID_WIDTH]
// with the sub-AFU's VMID, drops c0/c1 traffic while the sub-AFU is held in
// soft reset and counts the dropped requests. c2 MMIO read responses pass
// through untouched and are never dropped. Fixed 2-cycle latency on every
// channel (T1 = input capture, T2 = computed output register).
//
// Optional feature macro: VAI_TX_AUDIT_BOUNDS_EN
//   defined   : requests with guest address >= limit[41:0] are dropped and
//               counted in viol_cnt (limit = 0 disables the check).
//   undefined : no comparator, limit is ignored, viol_cnt is constant 0.
//
// Ports:
//   Clk        in   single clock
//   Resetb     in   synchronous active-low reset
//   offset     in   address offset, bits [41:0] used
//   soft_reset in   high = sub-AFU held, c0/c1 dropped
//   limit      in   guest address limit (bounds feature only)
//   in_tx      slave  Tx from the sub-AFU
//   out_tx     master audited Tx towards the mux
//   drop_cnt   out  saturating count of requests dropped under soft_reset
//   viol_cnt   out  saturating count of bounds violations
// ---------------------------------------------------------------------------
module vai_tx_audit #(
    parameter int VMID       = 0,
    parameter int VMID_WIDTH = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 Clk,
    input  logic                 Resetb,
    input  logic [63:0]          offset,
    input  logic                 soft_reset,
    input  logic [63:0]          limit,
    vai_tx_audit_if.slave        in_tx,
    vai_tx_audit_if.master       out_tx,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] viol_cnt
);
    localparam int AW = 42;
    localparam logic [VMID_WIDTH-1:0] VMID_TAG = VMID_WIDTH'(VMID);

    // ---------------- T1: input capture ----------------
    logic           t1_c0_valid, t1_c1_valid, t1_c2_valid, t1_soft_reset;
    logic [AW-1:0]  t1_offset;
    logic [AW-1:0]  t1_c0_address, t1_c1_address;
    logic [15:0]    t1_c0_mdata, t1_c1_mdata;
    logic [3:0]     t1_c0_req_type, t1_c1_req_type;
    logic [1:0]     t1_c0_cl_len, t1_c1_cl_len;
    logic [511:0]   t1_c1_data;
    logic [8:0]     t1_c2_tid;
    logic [63:0]    t1_c2_data;

    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            t1_c0_valid   <= 1'b0;
            t1_c1_valid   <= 1'b0;
            t1_c2_valid   <= 1'b0;
            t1_soft_reset <= 1'b0;
        end else begin
            t1_c0_valid   <= in_tx.c0_valid;
            t1_c1_valid   <= in_tx.c1_valid;
            t1_c2_valid   <= in_tx.c2_mmio_rd_valid;
            t1_soft_reset <= soft_reset;
        end
    end

    // Offset is captured alongside the request so a mid-stream offset write
    // only affects requests that enter T1 after it becomes visible.
    always_ff @(posedge Clk) begin
        t1_offset      <= offset[AW-1:0];
        t1_c0_address  <= in_tx.c0_address;
        t1_c0_mdata    <= in_tx.c0_mdata;
        t1_c0_req_type <= in_tx.c0_req_type;
        t1_c0_cl_len   <= in_tx.c0_cl_len;
        t1_c1_address  <= in_tx.c1_address;
        t1_c1_mdata    <= in_tx.c1_mdata;
        t1_c1_req_type <= in_tx.c1_req_type;
        t1_c1_cl_len   <= in_tx.c1_cl_len;
        t1_c1_data     <= in_tx.c1_data;
        t1_c2_tid      <= in_tx.c2_tid;
        t1_c2_data     <= in_tx.c2_data;
    end

`ifdef VAI_TX_AUDIT_BOUNDS_EN
    // Violation flags are resolved at T1 against the guest (pre-offset)
    // address; a zero limit switches the check off.
    logic t1_c0_viol, t1_c1_viol;
    logic limit_en;
    assign limit_en = (limit[AW-1:0] != '0);

    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            t1_c0_viol <= 1'b0;
            t1_c1_viol <= 1'b0;
        end else begin
            t1_c0_viol <= in_tx.c0_valid && limit_en && (in_tx.c0_address >= limit[AW-1:0]);
            t1_c1_viol <= in_tx.c1_valid && limit_en && (in_tx.c1_address >= limit[AW-1:0]);
        end
    end
`endif

    // ---------------- T2: decision and output register ----------------
    logic c0_emit, c1_emit, c0_drop, c1_drop;

    // soft_reset takes priority: a request that is also out of bounds is
    // counted only as a drop.
    assign c0_drop = t1_c0_valid && t1_soft_reset;
    assign c1_drop = t1_c1_valid && t1_soft_reset;
`ifdef VAI_TX_AUDIT_BOUNDS_EN
    logic c0_viol_hit, c1_viol_hit;
    assign c0_viol_hit = t1_c0_valid && !t1_soft_reset && t1_c0_viol;
    assign c1_viol_hit = t1_c1_valid && !t1_soft_reset && t1_c1_viol;
    assign c0_emit     = t1_c0_valid && !t1_soft_reset && !t1_c0_viol;
    assign c1_emit     = t1_c1_valid && !t1_soft_reset && !t1_c1_viol;
`else
    assign c0_emit     = t1_c0_valid && !t1_soft_reset;
    assign c1_emit     = t1_c1_valid && !t1_soft_reset;
`endif

    logic           t2_c0_valid, t2_c1_valid, t2_c2_valid;
    logic [AW-1:0]  t2_c0_address, t2_c1_address;
    logic [15:0]    t2_c0_mdata, t2_c1_mdata;
    logic [3:0]     t2_c0_req_type, t2_c1_req_type;
    logic [1:0]     t2_c0_cl_len, t2_c1_cl_len;
    logic [511:0]   t2_c1_data;
    logic [8:0]     t2_c2_tid;
    logic [63:0]    t2_c2_data;

    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            t2_c0_valid <= 1'b0;
            t2_c1_valid <= 1'b0;
            t2_c2_valid <= 1'b0;
        end else begin
            t2_c0_valid <= c0_emit;
            t2_c1_valid <= c1_emit;
            t2_c2_valid <= t1_c2_valid;
        end
    end

    // 42-bit add drops the carry, giving the silent modulo-2^42 wrap.
    always_ff @(posedge Clk) begin
        t2_c0_address  <= t1_c0_address + t1_offset;
        t2_c1_address  <= t1_c1_address + t1_offset;
        t2_c0_mdata    <= {VMID_TAG, t1_c0_mdata[15-VMID_WIDTH:0]};
        t2_c1_mdata    <= {VMID_TAG, t1_c1_mdata[15-VMID_WIDTH:0]};
        t2_c0_req_type <= t1_c0_req_type;
        t2_c1_req_type <= t1_c1_req_type;
        t2_c0_cl_len   <= t1_c0_cl_len;
        t2_c1_cl_len   <= t1_c1_cl_len;
        t2_c1_data     <= t1_c1_data;
        t2_c2_tid      <= t1_c2_tid;
        t2_c2_data     <= t1_c2_data;
    end

    assign out_tx.c0_valid         = t2_c0_valid;
    assign out_tx.c0_address       = t2_c0_address;
    assign out_tx.c0_mdata         = t2_c0_mdata;
    assign out_tx.c0_req_type      = t2_c0_req_type;
    assign out_tx.c0_cl_len        = t2_c0_cl_len;
    assign out_tx.c1_valid         = t2_c1_valid;
    assign out_tx.c1_address       = t2_c1_address;
    assign out_tx.c1_mdata         = t2_c1_mdata;
    assign out_tx.c1_req_type      = t2_c1_req_type;
    assign out_tx.c1_cl_len        = t2_c1_cl_len;
    assign out_tx.c1_data          = t2_c1_data;
    assign out_tx.c2_mmio_rd_valid = t2_c2_valid;
    assign out_tx.c2_tid           = t2_c2_tid;
    assign out_tx.c2_data          = t2_c2_data;

    // ---------------- Counters ----------------
    // One extra bit on the sum catches overflow; on overflow the counter
    // pins at all-ones rather than wrapping.
    logic [CNT_WIDTH-1:0] drop_q;
    logic [CNT_WIDTH:0]   drop_sum;

    assign drop_sum = {1'b0, drop_q} + (CNT_WIDTH+1)'(c0_drop) + (CNT_WIDTH+1)'(c1_drop);

    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            drop_q <= '0;
        end else if (drop_sum[CNT_WIDTH]) begin
            drop_q <= '1;
        end else begin
            drop_q <= drop_sum[CNT_WIDTH-1:0];
        end
    end

    assign drop_cnt = drop_q;

`ifdef VAI_TX_AUDIT_BOUNDS_EN
    logic [CNT_WIDTH-1:0] viol_q;
    logic [CNT_WIDTH:0]   viol_sum;

    assign viol_sum = {1'b0, viol_q} + (CNT_WIDTH+1)'(c0_viol_hit) + (CNT_WIDTH+1)'(c1_viol_hit);

    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            viol_q <= '0;
        end else if (viol_sum[CNT_WIDTH]) begin
            viol_q <= '1;
        end else begin
            viol_q <= viol_sum[CNT_WIDTH-1:0];
        end
    end

    assign viol_cnt = viol_q;

    logic unused_ok;
    assign unused_ok = ^{offset[63:AW], limit[63:AW]};
`else
    assign viol_cnt = '0;

    logic unused_ok;
    assign unused_ok = ^{offset[63:AW], limit};
`endif

endmodule
